// File: rtl/uart_rx_buffer.sv
// UART receiver: oversampled 8N1 deserialiser feeding an 8-deep first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data bits and the stop bit.
module uart_rx_buffer #(
   parameter int BUFFER_DEPTH = 8,
   parameter int BUFFER_WIDTH = 8,
   parameter int POINTER_SIZE = 3,
   parameter int OVERSAMPLE   = 16
) (
   input  logic                    sample_Clk,
   input  logic                    reset,
   input  logic                    rx_Serial,
   input  logic                    rd_Sig,
   output logic [BUFFER_WIDTH-1:0] rx_Data,
   output logic                    rx_Valid,
   output logic                    sig_Full,
   output logic                    sig_Empty,
   output logic                    frame_Err,
   output logic                    overrun_Err,
   output logic                    parity_Err
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(BUFFER_WIDTH);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BUFFER_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t state_q, state_d;

   logic                    rx_meta_q, rx_meta_d;
   logic                    rx_s_q, rx_s_d;
   logic [TICK_W-1:0]       tick_q, tick_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [BUFFER_WIDTH-1:0] shift_q, shift_d;
   logic [POINTER_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [POINTER_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic                    empty_q, empty_d;
   logic                    full_q, full_d;
   logic                    frame_err_q, frame_err_d;
   logic                    overrun_err_q, overrun_err_d;
   logic [BUFFER_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [BUFFER_WIDTH-1:0] mem_d [BUFFER_DEPTH];
`ifdef UART_RX_PARITY_EN
   logic                    par_bad_q, par_bad_d;
   logic                    parity_err_q, parity_err_d;
   logic                    parity_sample;
`endif

   logic                    at_mid, at_last;
   logic                    tick_clr, data_sample, stop_sample;
   logic                    byte_ok, do_push, do_pop;
   logic [POINTER_SIZE-1:0] wr_inc, rd_inc;

   always_ff @(posedge sample_Clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (!rx_s_q) state_d = START;
         START:  if (at_mid) state_d = rx_s_q ? IDLE : DATA;
         DATA:
            if (at_last && (bit_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
         PARITY: if (at_last) state_d = STOP;
`endif
         STOP:   if (at_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      at_mid      = (tick_q == TICK_MID);
      at_last     = (tick_q == TICK_LAST);
      data_sample = (state_q == DATA) && at_last;
      stop_sample = (state_q == STOP) && at_last;
`ifdef UART_RX_PARITY_EN
      parity_sample = (state_q == PARITY) && at_last;
`endif
      // START only counts up to mid-bit; every other busy state runs a full bit period.
      tick_clr = (state_q == IDLE) || ((state_q == START) ? at_mid : at_last);
   end

   always_comb begin
      rx_meta_d = rx_Serial;
      rx_s_d    = rx_meta_q;
      tick_d    = tick_clr ? '0 : tick_q + TICK_W'(1);

      bit_d   = bit_q;
      shift_d = shift_q;
      if (state_q == IDLE) begin
         bit_d = '0;
      end else if (data_sample) begin
         bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
         shift_d = {rx_s_q, shift_q[BUFFER_WIDTH-1:1]};
      end

`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      if (parity_sample) par_bad_d = rx_s_q ^ (^shift_q);
      byte_ok      = stop_sample && rx_s_q && !par_bad_q;
      parity_err_d = stop_sample && rx_s_q && par_bad_q;
`else
      byte_ok = stop_sample && rx_s_q;
`endif

      // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
      do_pop        = rd_Sig && !empty_q;
      do_push       = byte_ok && (!full_q || do_pop);
      frame_err_d   = stop_sample && !rx_s_q;
      overrun_err_d = byte_ok && full_q && !do_pop;

      wr_inc   = wr_ptr_q + POINTER_SIZE'(1);
      rd_inc   = rd_ptr_q + POINTER_SIZE'(1);
      wr_ptr_d = do_push ? wr_inc : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_inc : rd_ptr_q;

      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = shift_q;

      empty_d = empty_q;
      full_d  = full_q;
      if (do_push && !do_pop) begin
         empty_d = 1'b0;
         full_d  = (wr_inc == rd_ptr_q);
      end else if (do_pop && !do_push) begin
         full_d  = 1'b0;
         empty_d = (rd_inc == wr_ptr_q);
      end
   end

   always_ff @(posedge sample_Clk) begin
      if (reset) begin
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         tick_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= 1'b0;
         parity_err_q  <= 1'b0;
`endif
      end else begin
         rx_meta_q     <= rx_meta_d;
         rx_s_q        <= rx_s_d;
         tick_q        <= tick_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         empty_q       <= empty_d;
         full_q        <= full_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= par_bad_d;
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge sample_Clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rx_Data     = empty_q ? '0 : mem_q[rd_ptr_q];
      rx_Valid    = !empty_q;
      sig_Full    = full_q;
      sig_Empty   = empty_q;
      frame_Err   = frame_err_q;
      overrun_Err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
      parity_Err  = parity_err_q;
`else
      parity_Err  = 1'b0;
`endif
   end

endmodule
